// File: rtl/op_handler_dispatcher_pkg.sv
// Shared opcode, handler and dispatcher-state types for the opcode dispatcher.
package Op_PKG;

    localparam int unsigned OP_CMD_W = 4;

    typedef enum logic [OP_CMD_W-1:0] {
        OP_G00 = 4'd0,
        OP_G01 = 4'd1,
        OP_G02 = 4'd2,
        OP_G03 = 4'd3,
        OP_G90 = 4'd4,
        OP_G91 = 4'd5,
        OP_M05 = 4'd6
    } Op_cmd_t;

    typedef enum logic [1:0] {
        HANDLER_LIN   = 2'd0,
        HANDLER_CIRC  = 2'd1,
        HANDLER_DUMMY = 2'd2
    } Handler_t;

    typedef enum logic {
        DISP_IDLE   = 1'b0,
        DISP_ACTIVE = 1'b1
    } Disp_state_t;

    // Unknown encodings fall through to the dummy handler.
    function automatic Handler_t cmd_to_handler(input Op_cmd_t cmd);
        case (cmd)
            OP_G00, OP_G01: return HANDLER_LIN;
            OP_G02, OP_G03: return HANDLER_CIRC;
            default:        return HANDLER_DUMMY;
        endcase
    endfunction

    function automatic logic cmd_is_known(input Op_cmd_t cmd);
        case (cmd)
            OP_G00, OP_G01, OP_G02, OP_G03,
            OP_G90, OP_G91, OP_M05: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/op_handler_dispatcher_watchdog.sv
// Saturating cycle counter that flags when an owner has held the motors too long.
module op_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic w_unused;
            assign w_unused = &{1'b0, clk, reset, clear, enable};
            assign expired  = 1'b0;
        end else begin : g_on
            localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] r_cnt;

            // Count enabled cycles, holding at the limit until cleared.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cnt <= '0;
                end else if (clear) begin
                    r_cnt <= '0;
                end else if (enable && (r_cnt != LAST)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign expired = enable && (r_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/op_handler_dispatcher.sv
// Latches which opcode handler owns the motor and position-update paths
// until that handler signals completion or the watchdog fires.
module op_handler_dispatcher
    import Op_PKG::*;
#(
    parameter int unsigned NUM_HANDLERS   = 3,
    parameter int unsigned DUMMY_IDX      = 2,
    parameter int unsigned PULSE_W        = 16,
    parameter int unsigned POS_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [OP_CMD_W-1:0]               op_cmd,
    input  logic                              op_valid,
    output logic                              op_rdy,
    input  logic signed [PULSE_W-1:0]         h_pulse_num_x [NUM_HANDLERS],
    input  logic signed [PULSE_W-1:0]         h_pulse_num_y [NUM_HANDLERS],
    input  logic [NUM_HANDLERS-1:0]           h_servo_pos,
    input  logic [NUM_HANDLERS-1:0]           h_trigger,
    output logic [NUM_HANDLERS-1:0]           h_done,
    output logic [NUM_HANDLERS-1:0]           h_rdy,
    input  logic signed [POS_W-1:0]           h_new_x [NUM_HANDLERS],
    input  logic signed [POS_W-1:0]           h_new_y [NUM_HANDLERS],
    input  logic [NUM_HANDLERS-1:0]           h_update,
    input  logic [NUM_HANDLERS-1:0]           h_op_done,
    output logic signed [PULSE_W-1:0]         m_pulse_num_x,
    output logic signed [PULSE_W-1:0]         m_pulse_num_y,
    output logic                              m_servo_pos,
    output logic                              m_trigger,
    input  logic                              m_done,
    input  logic                              m_rdy,
    output logic signed [POS_W-1:0]           pos_new_x,
    output logic signed [POS_W-1:0]           pos_new_y,
    output logic                              pos_update,
    output logic [$clog2(NUM_HANDLERS)-1:0]   active_idx,
    output logic                              busy,
    output logic                              err_unknown_cmd,
    output logic                              err_timeout
);

    localparam int unsigned IDX_W = $clog2(NUM_HANDLERS);

    Disp_state_t      r_state;
    Disp_state_t      w_next_state;
    logic [IDX_W-1:0] r_sel;
    logic [IDX_W-1:0] w_cmd_idx;
    Handler_t         w_handler;
    logic             w_known;
    logic             w_accept;
    logic             w_owner_done;
    logic             w_active;
    logic             w_expired;
    logic             r_err_unknown;
    logic             r_err_timeout;

    assign w_active        = (r_state == DISP_ACTIVE);
    assign active_idx      = r_sel;
    assign err_unknown_cmd = r_err_unknown;
    assign err_timeout     = r_err_timeout;

    op_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_accept),
        .enable (w_active),
        .expired(w_expired)
    );

    // Decode the offered opcode into a handler channel index.
    always_comb begin
        w_handler = cmd_to_handler(Op_cmd_t'(op_cmd));
        w_known   = cmd_is_known(Op_cmd_t'(op_cmd));
        case (w_handler)
            HANDLER_LIN:  w_cmd_idx = IDX_W'(0);
            HANDLER_CIRC: w_cmd_idx = IDX_W'(1);
            default:      w_cmd_idx = IDX_W'(DUMMY_IDX);
        endcase
    end

    // Dispatcher state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= DISP_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Owner latch and registered one-cycle error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel         <= IDX_W'(DUMMY_IDX);
            r_err_unknown <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sel <= w_cmd_idx;
            end
            r_err_unknown <= w_accept && !w_known;
            // Completion in the expiry cycle takes priority: no error.
            r_err_timeout <= w_active && w_expired && !w_owner_done;
        end
    end

    // Next-state logic and combinational routing from the owning channel.
    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_owner_done  = 1'b0;
        op_rdy        = 1'b0;
        busy          = 1'b0;
        m_pulse_num_x = '0;
        m_pulse_num_y = '0;
        m_servo_pos   = 1'b0;
        m_trigger     = 1'b0;
        pos_new_x     = '0;
        pos_new_y     = '0;
        pos_update    = 1'b0;
        h_done        = '0;
        h_rdy         = '0;
        case (r_state)
            DISP_IDLE: begin
                op_rdy   = 1'b1;
                w_accept = op_valid;
                if (op_valid) begin
                    w_next_state = DISP_ACTIVE;
                end
            end
            DISP_ACTIVE: begin
                busy = 1'b1;
                for (int unsigned i = 0; i < NUM_HANDLERS; i++) begin
                    if (r_sel == IDX_W'(i)) begin
                        m_pulse_num_x = h_pulse_num_x[i];
                        m_pulse_num_y = h_pulse_num_y[i];
                        m_servo_pos   = h_servo_pos[i];
                        m_trigger     = h_trigger[i];
                        pos_new_x     = h_new_x[i];
                        pos_new_y     = h_new_y[i];
                        pos_update    = h_update[i];
                        h_done[i]     = m_done;
                        h_rdy[i]      = m_rdy;
                        w_owner_done  = h_op_done[i];
                    end
                end
                if (w_owner_done || w_expired) begin
                    w_next_state = DISP_IDLE;
                end
            end
            default: w_next_state = DISP_IDLE;
        endcase
    end

endmodule

// File: tb/tb_op_handler_dispatcher.sv
// Self-checking bench for op_handler_dispatcher with a short watchdog.
module tb_op_handler_dispatcher;
    import Op_PKG::*;

    localparam int unsigned NH = 3;
    localparam int unsigned PW = 16;
    localparam int unsigned QW = 16;
    localparam int unsigned TO = 8;

    logic                  clk;
    logic                  reset;
    logic [OP_CMD_W-1:0]   op_cmd;
    logic                  op_valid;
    logic                  op_rdy;
    logic signed [PW-1:0]  h_pulse_num_x [NH];
    logic signed [PW-1:0]  h_pulse_num_y [NH];
    logic [NH-1:0]         h_servo_pos;
    logic [NH-1:0]         h_trigger;
    logic [NH-1:0]         h_done;
    logic [NH-1:0]         h_rdy;
    logic signed [QW-1:0]  h_new_x [NH];
    logic signed [QW-1:0]  h_new_y [NH];
    logic [NH-1:0]         h_update;
    logic [NH-1:0]         h_op_done;
    logic signed [PW-1:0]  m_pulse_num_x;
    logic signed [PW-1:0]  m_pulse_num_y;
    logic                  m_servo_pos;
    logic                  m_trigger;
    logic                  m_done;
    logic                  m_rdy;
    logic signed [QW-1:0]  pos_new_x;
    logic signed [QW-1:0]  pos_new_y;
    logic                  pos_update;
    logic [1:0]            active_idx;
    logic                  busy;
    logic                  err_unknown_cmd;
    logic                  err_timeout;

    typedef struct {
        logic [1:0] idx;
        logic       unk;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    op_handler_dispatcher #(
        .NUM_HANDLERS  (NH),
        .DUMMY_IDX     (2),
        .PULSE_W       (PW),
        .POS_W         (QW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .op_cmd         (op_cmd),
        .op_valid       (op_valid),
        .op_rdy         (op_rdy),
        .h_pulse_num_x  (h_pulse_num_x),
        .h_pulse_num_y  (h_pulse_num_y),
        .h_servo_pos    (h_servo_pos),
        .h_trigger      (h_trigger),
        .h_done         (h_done),
        .h_rdy          (h_rdy),
        .h_new_x        (h_new_x),
        .h_new_y        (h_new_y),
        .h_update       (h_update),
        .h_op_done      (h_op_done),
        .m_pulse_num_x  (m_pulse_num_x),
        .m_pulse_num_y  (m_pulse_num_y),
        .m_servo_pos    (m_servo_pos),
        .m_trigger      (m_trigger),
        .m_done         (m_done),
        .m_rdy          (m_rdy),
        .pos_new_x      (pos_new_x),
        .pos_new_y      (pos_new_y),
        .pos_update     (pos_update),
        .active_idx     (active_idx),
        .busy           (busy),
        .err_unknown_cmd(err_unknown_cmd),
        .err_timeout    (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "bench time limit reached");
    end

    task automatic clear_inputs();
        for (int i = 0; i < NH; i++) begin
            h_pulse_num_x[i] = '0;
            h_pulse_num_y[i] = '0;
            h_new_x[i]       = '0;
            h_new_y[i]       = '0;
        end
        h_servo_pos = '0;
        h_trigger   = '0;
        h_update    = '0;
        h_op_done   = '0;
        op_valid    = 1'b0;
        op_cmd      = '0;
        m_done      = 1'b0;
        m_rdy       = 1'b0;
    endtask

    // Called at a negedge while IDLE; offers one opcode, returns one negedge later.
    task automatic offer(input logic [3:0] cmd, input logic [1:0] idx, input logic unk);
        exp_t e;
        n_checks++;
        if (op_rdy !== 1'b1) $display("FAIL offer_rdy cmd=%0d: op_rdy=%b required 1", cmd, op_rdy);
        else n_pass++;
        op_cmd   = cmd;
        op_valid = 1'b1;
        e.idx    = idx;
        e.unk    = unk;
        sb_q.push_back(e);
        @(negedge clk);
        op_valid = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if (active_idx !== e.idx) $display("FAIL accept_idx cmd=%0d: active_idx=%0d required %0d", cmd, active_idx, e.idx);
        else n_pass++;
        n_checks++;
        if (err_unknown_cmd !== e.unk) $display("FAIL accept_unk cmd=%0d: err_unknown_cmd=%b required %b", cmd, err_unknown_cmd, e.unk);
        else n_pass++;
        n_checks++;
        if ({busy, op_rdy} !== 2'b10) $display("FAIL accept_busy cmd=%0d: busy,op_rdy=%b required 10", cmd, {busy, op_rdy});
        else n_pass++;
    endtask

    task automatic finish_owner(input logic [1:0] idx);
        h_op_done[idx] = 1'b1;
        @(negedge clk);
        h_op_done = '0;
        n_checks++;
        if (op_rdy !== 1'b1) $display("FAIL finish_rdy idx=%0d: op_rdy=%b required 1", idx, op_rdy);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        m_done = 1'b1;
        m_rdy  = 1'b1;
        h_trigger = '1;
        h_update  = '1;
        h_pulse_num_x[2] = 16'sd7;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({op_rdy, busy, err_unknown_cmd, err_timeout} !== 4'b1000)
            $display("FAIL reset_status: rdy,busy,eu,et=%b required 1000", {op_rdy, busy, err_unknown_cmd, err_timeout});
        else n_pass++;
        n_checks++;
        if (active_idx !== 2'd2) $display("FAIL reset_idx: active_idx=%0d required 2", active_idx);
        else n_pass++;
        n_checks++;
        if ({m_trigger, pos_update, m_servo_pos, h_done, h_rdy} !== 9'b0 || m_pulse_num_x !== 16'sd0)
            $display("FAIL reset_outputs: trig=%b upd=%b done=%b rdy=%b px=%0d required all 0",
                     m_trigger, pos_update, h_done, h_rdy, m_pulse_num_x);
        else n_pass++;
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_linear();
        offer(4'(OP_G01), 2'd0, 1'b0);
        h_pulse_num_x[0] = 16'sd100;
        h_pulse_num_x[1] = 16'sd55;
        h_trigger[0]     = 1'b1;
        h_new_y[0]       = -16'sd3;
        h_update[0]      = 1'b1;
        m_done           = 1'b1;
        m_rdy            = 1'b1;
        #1;
        n_checks++;
        if (m_pulse_num_x !== 16'sd100 || m_trigger !== 1'b1)
            $display("FAIL lin_route: px=%0d trig=%b required 100 1", m_pulse_num_x, m_trigger);
        else n_pass++;
        n_checks++;
        if (h_done !== 3'b001 || h_rdy !== 3'b001)
            $display("FAIL lin_return: h_done=%b h_rdy=%b required 001 001", h_done, h_rdy);
        else n_pass++;
        n_checks++;
        if (pos_new_y !== -16'sd3 || pos_update !== 1'b1)
            $display("FAIL lin_pos: new_y=%0d upd=%b required -3 1", pos_new_y, pos_update);
        else n_pass++;
        finish_owner(2'd0);
        n_checks++;
        if (m_trigger !== 1'b0 || h_done !== 3'b000 || active_idx !== 2'd0)
            $display("FAIL lin_idle: trig=%b h_done=%b idx=%0d required 0 000 0", m_trigger, h_done, active_idx);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_circular();
        offer(4'(OP_G02), 2'd1, 1'b0);
        @(negedge clk);
        h_op_done[1] = 1'b1;
        #1;
        n_checks++;
        if (op_rdy !== 1'b0 || active_idx !== 2'd1)
            $display("FAIL circ_pulse: op_rdy=%b idx=%0d required 0 1", op_rdy, active_idx);
        else n_pass++;
        @(negedge clk);
        h_op_done = '0;
        n_checks++;
        if (op_rdy !== 1'b1 || active_idx !== 2'd1)
            $display("FAIL circ_after: op_rdy=%b idx=%0d required 1 1", op_rdy, active_idx);
        else n_pass++;
        offer(4'(OP_G00), 2'd0, 1'b0);
        finish_owner(2'd0);
    endtask

    task automatic test_unknown();
        offer(4'hF, 2'd2, 1'b1);
        @(negedge clk);
        n_checks++;
        if (err_unknown_cmd !== 1'b0) $display("FAIL unk_width: err_unknown_cmd=%b required 0", err_unknown_cmd);
        else n_pass++;
        finish_owner(2'd2);
        offer(4'(OP_M05), 2'd2, 1'b0);
        finish_owner(2'd2);
    endtask

    task automatic test_foreign();
        offer(4'(OP_G00), 2'd0, 1'b0);
        h_trigger[1]    = 1'b1;
        h_op_done[1]    = 1'b1;
        h_op_done[2]    = 1'b1;
        op_cmd          = 4'(OP_G02);
        op_valid        = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (m_trigger !== 1'b0 || busy !== 1'b1 || op_rdy !== 1'b0 || active_idx !== 2'd0)
                $display("FAIL foreign_%0d: trig=%b busy=%b rdy=%b idx=%0d required 0 1 0 0",
                         k, m_trigger, busy, op_rdy, active_idx);
            else n_pass++;
        end
        clear_inputs();
        finish_owner(2'd0);
    endtask

    task automatic test_watchdog();
        int pulses = 0;
        int first  = -1;
        offer(4'(OP_G00), 2'd0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = k;
                    n_checks++;
                    if (busy !== 1'b0 || op_rdy !== 1'b1)
                        $display("FAIL wd_idle: busy=%b rdy=%b required 0 1", busy, op_rdy);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (pulses != 1 || first != 8)
            $display("FAIL wd_pulse: pulses=%0d at cycle %0d required 1 at cycle 8", pulses, first);
        else n_pass++;
        offer(4'(OP_G03), 2'd1, 1'b0);
        repeat (7) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL wd_pre: busy=%b required 1", busy);
        else n_pass++;
        h_op_done[1] = 1'b1;
        @(negedge clk);
        h_op_done = '0;
        n_checks++;
        if (err_timeout !== 1'b0 || op_rdy !== 1'b1)
            $display("FAIL wd_coincide: err_timeout=%b rdy=%b required 0 1", err_timeout, op_rdy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (err_timeout !== 1'b0) $display("FAIL wd_coincide_late: err_timeout=%b required 0", err_timeout);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] cmds [3];
        logic [1:0] idxs [3];
        cmds[0] = 4'(OP_G00); idxs[0] = 2'd0;
        cmds[1] = 4'(OP_G03); idxs[1] = 2'd1;
        cmds[2] = 4'(OP_G91); idxs[2] = 2'd2;
        for (int i = 0; i < 3; i++) begin
            offer(cmds[i], idxs[i], 1'b0);
            finish_owner(idxs[i]);
        end
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL b2b_sb: %0d entries left required 0", sb_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        offer(4'(OP_G02), 2'd1, 1'b0);
        h_trigger[1] = 1'b1;
        m_done       = 1'b1;
        #1;
        n_checks++;
        if (m_trigger !== 1'b1 || h_done !== 3'b010)
            $display("FAIL rst_mid_pre: trig=%b h_done=%b required 1 010", m_trigger, h_done);
        else n_pass++;
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({op_rdy, busy, m_trigger, err_unknown_cmd, err_timeout} !== 5'b10000 || h_done !== 3'b000)
            $display("FAIL rst_mid: rdy,busy,trig,eu,et=%b h_done=%b required 10000 000",
                     {op_rdy, busy, m_trigger, err_unknown_cmd, err_timeout}, h_done);
        else n_pass++;
        n_checks++;
        if (active_idx !== 2'd2) $display("FAIL rst_mid_idx: active_idx=%0d required 2", active_idx);
        else n_pass++;
        #1 reset = 1'b1;
        clear_inputs();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_linear();
        test_circular();
        test_unknown();
        test_foreign();
        test_watchdog();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
